// File: rtl/writeback_stage.sv
// Writeback stage register: captures the MEM-stage entry, selects the register-file write index and data,
// drives the forwarding copies and counts retired instructions. One-cycle latency; stall holds, flush bubbles.
module writeback_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        inValid,
   input  logic        inRegWrite,
   input  logic        inMemToReg,
   input  logic        inLink,
   input  logic [4:0]  inRd,
   input  logic [31:0] inAluResult,
   input  logic [31:0] inMemData,
   input  logic [31:0] inPcPlus4,
   output logic        regWrite,
   output logic [4:0]  writeRegister,
   output logic [31:0] writeData,
   output logic        fwdValid,
   output logic [4:0]  fwdRegister,
   output logic [31:0] fwdData,
   output logic [31:0] retireCount
);

   logic        valid_q,        valid_d;
   logic        reg_write_q,    reg_write_d;
   logic        mem_to_reg_q,   mem_to_reg_d;
   logic        link_q,         link_d;
   logic [4:0]  rd_q,           rd_d;
   logic [31:0] alu_result_q,   alu_result_d;
   logic [31:0] mem_data_q,     mem_data_d;
   logic [31:0] pc_plus4_q,     pc_plus4_d;
   logic [31:0] retire_count_q, retire_count_d;

   // Priority: reset > flush > stall > load. Flush only needs to clear valid.
   always_comb begin
      valid_d        = valid_q;
      reg_write_d    = reg_write_q;
      mem_to_reg_d   = mem_to_reg_q;
      link_d         = link_q;
      rd_d           = rd_q;
      alu_result_d   = alu_result_q;
      mem_data_d     = mem_data_q;
      pc_plus4_d     = pc_plus4_q;
      retire_count_d = retire_count_q;
      if (reset) begin
         valid_d        = 1'b0;
         reg_write_d    = 1'b0;
         mem_to_reg_d   = 1'b0;
         link_d         = 1'b0;
         rd_d           = 5'd0;
         alu_result_d   = 32'd0;
         mem_data_d     = 32'd0;
         pc_plus4_d     = 32'd0;
         retire_count_d = 32'd0;
      end else if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d      = inValid;
         reg_write_d  = inRegWrite;
         mem_to_reg_d = inMemToReg;
         link_d       = inLink;
         rd_d         = inRd;
         alu_result_d = inAluResult;
         mem_data_d   = inMemData;
         pc_plus4_d   = inPcPlus4;
         if (inValid) begin
            retire_count_d = retire_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      link_q         <= link_d;
      rd_q           <= rd_d;
      alu_result_q   <= alu_result_d;
      mem_data_q     <= mem_data_d;
      pc_plus4_q     <= pc_plus4_d;
      retire_count_q <= retire_count_d;
   end

   // Link targets x31 with the return address; link outranks memToReg.
   always_comb begin
      writeRegister = link_q ? 5'd31 : rd_q;
      if (link_q) begin
         writeData = pc_plus4_q + 32'd4;
      end else if (mem_to_reg_q) begin
         writeData = mem_data_q;
      end else begin
         writeData = alu_result_q;
      end
      regWrite      = valid_q && (reg_write_q || link_q) && (writeRegister != 5'd0);
      fwdValid      = regWrite;
      fwdRegister   = writeRegister;
      fwdData       = writeData;
      retireCount   = retire_count_q;
   end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk is the single clock, and reset is sampled only on the rising edge of clk.
REQ-002 Port: clk  in  1  single clock; the stage register updates on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: stall  in  1  hold the stage register contents.
REQ-005 Port: flush  in  1  load a bubble (invalid entry).
REQ-006 Port: inValid  in  1  the incoming MEM-stage entry is a real instruction.
REQ-007 Port: inRegWrite  in  1  the instruction writes a register.
REQ-008 Port: inMemToReg  in  1  the write data comes from memory data, not the ALU result.
REQ-009 Port: inLink  in  1  the instruction is a link (jal/jalr-style) instruction.
REQ-010 Port: inRd  in  5  destination register index.
REQ-011 Port: inAluResult  in  32  ALU result.
REQ-012 Port: inMemData  in  32  load data.
REQ-013 Port: inPcPlus4  in  32  PC+4 of the instruction.
REQ-014 Port: regWrite  out  1  register-file write enable.
REQ-015 Port: writeRegister  out  5  register-file write index.
REQ-016 Port: writeData  out  32  register-file write data.
REQ-017 Port: fwdValid  out  1  a forwarding source is present (equals regWrite).
REQ-018 Port: fwdRegister  out  5  forwarding index (equals writeRegister).
REQ-019 Port: fwdData  out  32  forwarding data (equals writeData).
REQ-020 Port: retireCount  out  32  count of retired instructions.

Function
REQ-021 The stage register (valid, regWrite, memToReg, link, rd, aluResult, memData, pcPlus4) SHALL update only on the rising edge of clk.
- Priority: reset > flush > stall > load.
REQ-022 Load: when stall=0 and flush=0, all in* fields SHALL be captured; outputs reflect them after that edge.
- Latency: one clock from input to outputs.
- The register file commits the write at the following falling edge.
REQ-023 Stall: when stall=1 and flush=0, all stored fields SHALL hold.
- Outputs remain unchanged.
- Re-asserting regWrite for the held entry is permitted (idempotent rewrite).
REQ-024 Flush: when flush=1 (regardless of stall), stored valid SHALL be cleared to 0; the other fields are don't-care.
REQ-025 writeRegister SHALL be 5'd31 when the stored link=1, otherwise the stored rd.
REQ-026 writeData SHALL be selected as follows:
- link=1: pcPlus4+4, mod 2^32 (link wins over memToReg);
- else memToReg=1: memData;
- else: aluResult.
REQ-027 regWrite SHALL equal valid AND (stored regWrite OR link) AND (writeRegister != 0).
- Writes to register 0 are always suppressed.
REQ-028 When regWrite=0, writeRegister and writeData SHALL still follow REQ-025/026; consumers qualify them with regWrite.
REQ-029 fwdValid, fwdRegister and fwdData SHALL be combinational copies of regWrite, writeRegister and writeData.
REQ-030 retireCount SHALL increment by 1 on each rising edge where reset=0, flush=0, stall=0 and inValid=1.
- It wraps from 32'hFFFFFFFF to 0.
- It does not increment while stalled, so no double count.
REQ-031 Simultaneous flush and inValid=1 SHALL NOT increment retireCount.

Reset
REQ-032 On a rising edge with reset=1, the block SHALL:
- clear valid, regWrite, memToReg and link;
- set rd, aluResult, memData and pcPlus4 to 0;
- set retireCount to 0.
REQ-033 During and after reset, outputs SHALL read regWrite=0, writeRegister=0, writeData=0, fwdValid=0, retireCount=0 until the first load.
REQ-034 Reset asserted mid-stall or mid-flush SHALL override both.
- The held entry is discarded.
- No register-file write occurs in the cycle following reset.

Verification
REQ-035 ALU write: inValid=1, inRegWrite=1, inRd=8, inAluResult=32'h0000_1234 -> next cycle regWrite=1, writeRegister=8, writeData=32'h0000_1234, retireCount=1.
REQ-036 Load vs link priority:
- inMemToReg=1, inMemData=32'hDEAD_BEEF, inRd=9 -> writeData=32'hDEAD_BEEF.
- Then inLink=1, inMemToReg=1, inPcPlus4=32'h0040_0010 -> writeRegister=31, writeData=32'h0040_0014.
REQ-037 Zero register: inRegWrite=1, inRd=0, inValid=1 -> regWrite=0, fwdValid=0, retireCount increments.
REQ-038 Stall/flush:
- Load entry (rd=5), then stall=1 for 3 cycles with changing inputs -> outputs hold rd=5, retireCount unchanged.
- stall=1 with flush=1 -> regWrite=0, retireCount unchanged.
REQ-039 Wrap and reset:
- Preload 32'hFFFFFFFF retires, one more valid load -> retireCount=0.
- Assert reset during a stall -> all outputs 0 next cycle.
